// File: rtl/reg_exec_pkg.sv
// Shared opcodes, FSM states and default widths for the register-file sequencer.
package reg_exec_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/reg_exec_seq_alu.sv
// Combinational ALU for the sequencer; cout is only meaningful for ADD/SUB.
module seq_alu
    import reg_exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] res,
    output logic              cout
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        res  = '0;
        cout = 1'b0;
        case (op)
            OP_ADD: begin
                res  = sum[DATA_W-1:0];
                cout = sum[DATA_W];
            end
            OP_SUB: begin
                res  = a - b;
                cout = (a < b);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MOV:  res = a;
            OP_LDI:  res = imm;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/reg_exec_seq.sv
// Four-state sequencer: accept instruction, read register file, compute, write back
// with a single registered load pulse.
module reg_exec_seq
    import reg_exec_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instValid,
    output logic                  instReady,
    input  logic [2:0]            instOp,
    input  logic [REG_ADDR_W-1:0] instRd,
    input  logic [REG_ADDR_W-1:0] instRs1,
    input  logic [REG_ADDR_W-1:0] instRs2,
    input  logic [DATA_W-1:0]     instImm,
    output logic [REG_ADDR_W-1:0] sel1,
    output logic [REG_ADDR_W-1:0] sel2,
    output logic [REG_ADDR_W-1:0] dataSel,
    output logic [DATA_W-1:0]     dataIn,
    output logic                  load,
    input  logic [DATA_W-1:0]     dataOut1,
    input  logic [DATA_W-1:0]     dataOut2,
    output logic [DATA_W-1:0]     result,
    output logic                  carry,
    output logic                  done
);

    state_t                  state;
    logic [2:0]              opReg;
    logic [REG_ADDR_W-1:0]   rdReg;
    logic [DATA_W-1:0]       immReg;
    logic [DATA_W-1:0]       aluRes;
    logic                    aluCout;

    seq_alu #(.DATA_W(DATA_W)) uAlu (
        .op   (opReg),
        .a    (dataOut1),
        .b    (dataOut2),
        .imm  (immReg),
        .res  (aluRes),
        .cout (aluCout)
    );

    always_comb instReady = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sel1    <= '0;
            sel2    <= '0;
            dataSel <= '0;
            dataIn  <= '0;
            result  <= '0;
            carry   <= 1'b0;
            load    <= 1'b0;
            done    <= 1'b0;
            opReg   <= OP_NOP;
            rdReg   <= '0;
            immReg  <= '0;
        end else begin
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instValid) begin
                        sel1   <= instRs1;
                        sel2   <= instRs2;
                        opReg  <= instOp;
                        rdReg  <= instRd;
                        immReg <= instImm;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Operands are consumed straight from the read ports at the end of READ,
                    // so dataIn/dataSel settle during EXEC, a full cycle ahead of load.
                    if (opReg != OP_NOP) begin
                        result  <= aluRes;
                        dataIn  <= aluRes;
                        dataSel <= rdReg;
                        if (opReg == OP_ADD || opReg == OP_SUB)
                            carry <= aluCout;
                    end
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opReg == OP_NOP) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        load  <= 1'b1;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_exec_seq.sv
// Directed bench for reg_exec_seq with a register-file model and a cycle-level reference model.
module tb_reg_exec_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instValid;
    logic        instReady;
    logic [2:0]  instOp;
    logic [2:0]  instRd;
    logic [2:0]  instRs1;
    logic [2:0]  instRs2;
    logic [15:0] instImm;
    logic [2:0]  sel1;
    logic [2:0]  sel2;
    logic [2:0]  dataSel;
    logic [15:0] dataIn;
    logic        load;
    logic [15:0] dataOut1;
    logic [15:0] dataOut2;
    logic [15:0] result;
    logic        carry;
    logic        done;

    int passed = 0;
    int total  = 0;

    reg_exec_seq #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .instValid (instValid),
        .instReady (instReady),
        .instOp    (instOp),
        .instRd    (instRd),
        .instRs1   (instRs1),
        .instRs2   (instRs2),
        .instImm   (instImm),
        .sel1      (sel1),
        .sel2      (sel2),
        .dataSel   (dataSel),
        .dataIn    (dataIn),
        .load      (load),
        .dataOut1  (dataOut1),
        .dataOut2  (dataOut2),
        .result    (result),
        .carry     (carry),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Register file: combinational reads, write on the rising edge of load.
    logic [15:0] rf [8];
    int loadCount = 0;
    initial for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    always @(posedge load) begin
        rf[dataSel] <= dataIn;
        loadCount++;
    end
    assign dataOut1 = rf[sel1];
    assign dataOut2 = rf[sel2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: architectural registers plus the observable timeline of one instruction.
    logic [15:0] gold [8];
    initial for (int i = 0; i < 8; i++) gold[i] = 16'h0000;
    int tcount = 0;
    int readCyc = -1, execCyc = -1, loadCyc = -1, doneCyc = -1, readyAt = 0;
    int xferQ[$];
    logic [2:0]  pSel1, pSel2, pRd;
    logic [15:0] pRes;
    logic        pCarry, pArith, pWrite;
    logic [2:0]  mSel1 = 0, mSel2 = 0, mDataSel = 0;
    logic [15:0] mDataIn = 0, mRes = 0;
    logic        mCarry = 0;

    always @(negedge clk) begin
        logic [16:0] sum;
        logic [15:0] a, b;
        tcount++;
        if (tcount == readCyc) begin
            mSel1 = pSel1;
            mSel2 = pSel2;
        end
        if (tcount == execCyc && pWrite) begin
            mRes     = pRes;
            mDataIn  = pRes;
            mDataSel = pRd;
            if (pArith) mCarry = pCarry;
        end
        if (tcount == loadCyc) gold[pRd] = pRes;

        check("instReady", instReady, tcount >= readyAt);
        check("load",      load,      tcount == loadCyc);
        check("done",      done,      tcount == doneCyc);
        check("sel1",      sel1,      mSel1);
        check("sel2",      sel2,      mSel2);
        check("dataSel",   dataSel,   mDataSel);
        check("dataIn",    dataIn,    mDataIn);
        check("result",    result,    mRes);
        check("carry",     carry,     mCarry);

        if (rst) begin
            mSel1 = 0; mSel2 = 0; mDataSel = 0; mDataIn = 0; mRes = 0; mCarry = 0;
            readCyc = -1; execCyc = -1; loadCyc = -1; doneCyc = -1; readyAt = 0;
        end else if (instValid && tcount >= readyAt) begin
            a = gold[instRs1];
            b = gold[instRs2];
            pSel1 = instRs1; pSel2 = instRs2; pRd = instRd;
            pCarry = 1'b0;
            pArith = (instOp == 3'd0 || instOp == 3'd1);
            pWrite = (instOp != 3'd7);
            case (instOp)
                3'd0: begin sum = 17'(a) + 17'(b); pRes = sum[15:0]; pCarry = sum[16]; end
                3'd1: begin pRes = a - b; pCarry = (a < b); end
                3'd2: pRes = a & b;
                3'd3: pRes = a | b;
                3'd4: pRes = a ^ b;
                3'd5: pRes = a;
                3'd6: pRes = instImm;
                default: pRes = 16'h0000;
            endcase
            readCyc = tcount + 1;
            execCyc = tcount + 2;
            loadCyc = pWrite ? tcount + 3 : -1;
            doneCyc = pWrite ? tcount + 4 : tcount + 3;
            readyAt = doneCyc;
            xferQ.push_back(tcount);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm);
        instOp = op; instRd = rd; instRs1 = rs1; instRs2 = rs2; instImm = imm;
        instValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instReady) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        $display("FAIL issueTimeout: got no transfer expected transfer within 20 cycles");
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instReady) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        $display("FAIL idleTimeout: got busy expected idle within 20 cycles");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL globalTimeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int q0, loads0;
        rst = 1'b1; instValid = 1'b0;
        instOp = 3'd7; instRd = 0; instRs1 = 0; instRs2 = 0; instImm = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rstReady",   instReady, 1);
        check("rstLoad",    load,      0);
        check("rstDone",    done,      0);
        check("rstResult",  result,    0);
        check("rstCarry",   carry,     0);
        check("rstDataSel", dataSel,   0);
        check("rstDataIn",  dataIn,    0);

        // LDI r1 = 3 with explicit cycle-by-cycle timing
        issue(3'd6, 3'd1, 3'd0, 3'd0, 16'h0003);
        instValid = 1'b0;
        check("ldiReadLoad", load, 0);
        step();
        check("ldiExecLoad", load, 0);
        check("ldiExecSel",  dataSel, 1);
        check("ldiExecData", dataIn, 16'h0003);
        step();
        check("ldiWriteLoad", load, 1);
        check("ldiWriteDone", done, 0);
        step();
        check("ldiIdleLoad", load, 0);
        check("ldiIdleDone", done, 1);
        check("ldiR1",       rf[1], 16'h0003);
        check("ldiGoldR1",   gold[1], 16'h0003);

        issue(3'd6, 3'd2, 3'd0, 3'd0, 16'h0005); instValid = 1'b0; waitIdle();

        issue(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000); instValid = 1'b0; waitIdle();
        check("addR3",     rf[3],  16'h0008);
        check("addResult", result, 16'h0008);
        check("addCarry",  carry,  0);

        issue(3'd1, 3'd4, 3'd1, 3'd2, 16'h0000); instValid = 1'b0; waitIdle();
        check("subR4",    rf[4], 16'hFFFE);
        check("subCarry", carry, 1);

        issue(3'd6, 3'd5, 3'd0, 3'd0, 16'hFFFF); instValid = 1'b0; waitIdle();
        issue(3'd6, 3'd6, 3'd0, 3'd0, 16'h0001); instValid = 1'b0; waitIdle();
        issue(3'd0, 3'd7, 3'd5, 3'd6, 16'h0000); instValid = 1'b0; waitIdle();
        check("wrapR7",     rf[7],  16'h0000);
        check("wrapResult", result, 16'h0000);
        check("wrapCarry",  carry,  1);

        issue(3'd4, 3'd0, 3'd1, 3'd2, 16'h0000); instValid = 1'b0; waitIdle();
        check("xorR0",    rf[0],  16'h0006);
        check("xorCarry", carry,  1);

        // NOP then AND with instValid held high
        loads0 = loadCount;
        issue(3'd7, 3'd0, 3'd0, 3'd0, 16'h0000);
        issue(3'd2, 3'd2, 3'd2, 3'd2, 16'h0000);
        instValid = 1'b0; waitIdle();
        check("nopAndGap",   xferQ[xferQ.size()-1] - xferQ[xferQ.size()-2], 3);
        check("nopAndLoads", loadCount - loads0, 1);
        check("andR2",       rf[2], 16'h0005);

        // Three back-to-back writes
        loads0 = loadCount;
        q0 = xferQ.size();
        issue(3'd3, 3'd5, 3'd1, 3'd2, 16'h0000);
        issue(3'd1, 3'd6, 3'd2, 3'd1, 16'h0000);
        issue(3'd5, 3'd1, 3'd4, 3'd0, 16'h0000);
        instValid = 1'b0; waitIdle();
        check("b2bGap1",  xferQ[q0+1] - xferQ[q0], 4);
        check("b2bGap2",  xferQ[q0+2] - xferQ[q0+1], 4);
        check("b2bLoads", loadCount - loads0, 3);
        check("orR5",     rf[5], 16'h0007);
        check("subR6",    rf[6], 16'h0002);
        check("movR1",    rf[1], 16'hFFFE);
        check("b2bCarry", carry, 0);

        // Reset in the WRITE cycle: the write lands, done never pulses
        issue(3'd6, 3'd3, 3'd0, 3'd0, 16'h1234);
        instValid = 1'b0;
        step();
        step();
        check("rwLoadHigh", load, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rwLoad", load, 0);
        check("rwDone", done, 0);
        check("rwR3",   rf[3], 16'h1234);
        step();
        check("rwDoneLater", done, 0);

        // Reset in the EXEC cycle: no write, everything cleared
        loads0 = loadCount;
        issue(3'd0, 3'd4, 3'd1, 3'd2, 16'h0000);
        instValid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reSel1",    sel1,    0);
        check("reSel2",    sel2,    0);
        check("reDataSel", dataSel, 0);
        check("reDataIn",  dataIn,  0);
        check("reResult",  result,  0);
        check("reCarry",   carry,   0);
        check("reLoad",    load,    0);
        check("reDone",    done,    0);
        check("reReady",   instReady, 1);
        repeat (3) step();
        check("reLoads", loadCount - loads0, 0);
        check("reR4",    rf[4], 16'hFFFE);

        for (int i = 0; i < 8; i++) check($sformatf("rf%0d", i), rf[i], gold[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
